diagnosis_pc_monitor_mc: RTL and testbench
==========================================

Name: diagnosis_pc_monitor_mc

Overview:
Multi-channel, parametrised successor of the single-core program-counter monitor in the diagnosis system. It watches CHANNELS execution trace ports against EVENTS configurable PC entries, supporting exact, one-shot and range match modes. Matches are timestamped and buffered per channel. A round-robin arbiter merges them onto one valid/ready event stream that feeds the LUT/packetizer path. Dropped events are counted and flagged.

Parameters:
CHANNELS, 2, number of trace channels (cores/harts), 1..8
EVENTS, 4, number of config entries, 1..16
PC_WIDTH, 32, program counter width
TS_WIDTH, 16, timestamp width
EV_ID_WIDTH, 5, event ID width
FIFO_DEPTH, 4, per-channel event FIFO depth, power of 2, >=2

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
diag_sys_enabled  in  1  global monitor enable
conf_pc_flat_in  in  48*EVENTS  entry i = bits [48i+47:48i]: [47] valid, [46:45] mode (00 exact, 01 one-shot, 10 range-low, 11 reserved = disabled), [EV_ID_WIDTH-1+32:32] ev_id, [31:0] pc (low PC_WIDTH bits used)
conf_rearm  in  1  single-cycle pulse, re-arms all one-shot entries
pc_val  in  PC_WIDTH*CHANNELS  per-channel retired PC
pc_enable  in  CHANNELS  per-channel PC valid
time_global  in  TS_WIDTH  global timestamp
ev_valid  out  1  event available
ev_ready  in  1  consumer accepts event
ev_id  out  EV_ID_WIDTH  matched event ID
ev_time  out  TS_WIDTH  timestamp of the match cycle
ev_channel  out  3  originating channel
ev_overflow  out  1  at least one event from this channel was dropped before this one
overflow_count  out  16  saturating total of dropped events

Behaviour:
- Reset (rst low, asynchronous): ev_valid=0, ev_id=0, ev_time=0, ev_channel=0, ev_overflow=0, overflow_count=0. All FIFOs are emptied, all one-shot entries are armed, arbiter pointer=0, per-channel drop flags are cleared. Reset release takes effect on the next clk edge.
- Match stage (cycle N): for each channel c with pc_enable[c]=1 and diag_sys_enabled=1, evaluate every valid entry.
  - Exact: pc==entry.pc.
  - One-shot: like exact, but only while the entry is armed.
  - Range-low at entry i (i<EVENTS-1): entry.pc <= pc < entry(i+1).pc, unsigned. Entry i+1 is then used only as the upper bound and never matches standalone. Range-low at the last entry never matches.
  - Lowest-index matching entry wins; at most one event per channel per cycle.
- The match result is registered with time_global sampled in cycle N. The FIFO write happens in cycle N+1.
- One-shot disarm: a one-shot entry that wins on any channel is disarmed at the end of cycle N. If several channels hit the same one-shot entry in cycle N, all of them get the event; disarm takes effect from N+1. conf_rearm re-arms in the following cycle. If conf_rearm and a hit coincide, the hit is reported and the entry ends armed.
- FIFO full: a write to a full FIFO drops the event. overflow_count increments, saturating at 0xFFFF. If several channels drop in one cycle, add the number of drops, saturating. The channel's drop flag is set, travels with that channel's next successfully queued event as ev_overflow=1, then clears.
- Output register: it loads when empty or when ev_valid&ev_ready. The arbiter picks the first non-empty FIFO starting at the pointer. After a grant to channel c, pointer=(c+1) mod CHANNELS.
- Latency: empty path from pc_enable to ev_valid is 2 cycles. Throughput is 1 event/cycle with ev_ready held high.
- Handshake: ev_valid and all payload stay stable until ev_ready. ev_valid never drops without a handshake.
- diag_sys_enabled=0 stops new matches only; queued events still drain.
- Configuration changes take effect from the next match evaluation. Queued events are unaffected.

Test Plan:
- Exact match: entry0={valid,exact,id=3,pc=0x100}, ch0 pc=0x100 at time 0x20 -> 2 cycles later ev_valid=1, ev_id=3, ev_time=0x20, ev_channel=0, ev_overflow=0.
- Range/priority: entry1=range-low 0x200, entry2.pc=0x300, entry0 exact 0x250 id=1. pc=0x250 gives id=1; pc=0x2FF gives entry1's id; pc=0x300 gives no event unless entry2 matches standalone (it must not).
- One-shot: entry0 one-shot id=7, pc=0x40 on ch0 three times -> exactly one event. After a conf_rearm pulse, the next hit gives one more event.
- Arbitration: CHANNELS=2, both channels match every cycle for 4 cycles, ev_ready=1 -> ev_channel alternates 0,1,0,1,... with no loss.
- Overflow: ev_ready=0, ch1 issues 6 matches with FIFO_DEPTH=4 -> overflow_count=1 (one FIFO entry sits in the output register), ch1's fifth queued event carries ev_overflow=1. overflow_count saturates at 0xFFFF.
- Reset mid-stream: assert rst low while ev_valid=1 and FIFOs are non-empty -> all outputs go 0 immediately, no stale event appears after release, and one-shot entries are re-armed.

Source files
------------

// File: rtl/diagnosis_pc_monitor_mc.sv
// rtl/diagnosis_pc_monitor_mc.sv - multi-channel PC match monitor with per-channel event FIFOs
`timescale 1ns/1ps
module diagnosis_pc_monitor_mc #(
  parameter int CHANNELS    = 2,
  parameter int EVENTS      = 4,
  parameter int PC_WIDTH    = 32,
  parameter int TS_WIDTH    = 16,
  parameter int EV_ID_WIDTH = 5,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         diag_sys_enabled,
  input  logic [48*EVENTS-1:0]         conf_pc_flat_in,
  input  logic                         conf_rearm,
  input  logic [PC_WIDTH*CHANNELS-1:0] pc_val,
  input  logic [CHANNELS-1:0]          pc_enable,
  input  logic [TS_WIDTH-1:0]          time_global,
  output logic                         ev_valid,
  input  logic                         ev_ready,
  output logic [EV_ID_WIDTH-1:0]       ev_id,
  output logic [TS_WIDTH-1:0]          ev_time,
  output logic [2:0]                   ev_channel,
  output logic                         ev_overflow,
  output logic [15:0]                  overflow_count
);
  localparam int EW = 1 + TS_WIDTH + EV_ID_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [EVENTS-1:0]      e_valid, e_bound, armed, os_hit;
  logic [1:0]             e_mode [EVENTS];
  logic [EV_ID_WIDTH-1:0] e_id [EVENTS];
  logic [PC_WIDTH-1:0]    e_pc [EVENTS+1];
  logic                   unused_conf;

  assign unused_conf = ^conf_pc_flat_in;

  // An entry directly after a valid range-low entry only serves as its upper bound.
  always_comb begin
    e_bound = '0;
    e_pc[EVENTS] = '0;
    for (int i = 0; i < EVENTS; i++) begin
      e_valid[i] = conf_pc_flat_in[48*i+47];
      e_mode[i]  = conf_pc_flat_in[48*i+45 +: 2];
      e_id[i]    = conf_pc_flat_in[48*i+32 +: EV_ID_WIDTH];
      e_pc[i]    = conf_pc_flat_in[48*i +: PC_WIDTH];
    end
    for (int i = 1; i < EVENTS; i++)
      e_bound[i] = e_valid[i-1] && (e_mode[i-1] == 2'b10);
  end

  logic [CHANNELS-1:0]    hit;
  logic [EV_ID_WIDTH-1:0] hit_id [CHANNELS];

  always_comb begin : match
    logic [PC_WIDTH-1:0] pc;
    logic m, found;
    pc = '0;
    m = 1'b0;
    found = 1'b0;
    hit = '0;
    os_hit = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      hit_id[c] = '0;
      found = 1'b0;
      pc = pc_val[c*PC_WIDTH +: PC_WIDTH];
      for (int i = 0; i < EVENTS; i++) begin
        case (e_mode[i])
          2'b00:   m = (pc == e_pc[i]);
          2'b01:   m = armed[i] && (pc == e_pc[i]);
          2'b10:   m = (i < EVENTS - 1) && (pc >= e_pc[i]) && (pc < e_pc[i+1]);
          default: m = 1'b0;
        endcase
        if (!found && m && e_valid[i] && !e_bound[i] && diag_sys_enabled && pc_enable[c]) begin
          found = 1'b1;
          hit[c] = 1'b1;
          hit_id[c] = e_id[i];
          if (e_mode[i] == 2'b01) os_hit[i] = 1'b1;
        end
      end
    end
  end

  logic [CHANNELS-1:0]    m_valid;
  logic [EV_ID_WIDTH-1:0] m_id [CHANNELS];
  logic [TS_WIDTH-1:0]    m_time;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid <= '0;
      m_time  <= '0;
      armed   <= '1;
      for (int c = 0; c < CHANNELS; c++) m_id[c] <= '0;
    end else begin
      m_valid <= hit;
      m_time  <= time_global;
      armed   <= conf_rearm ? '1 : (armed & ~os_hit);
      for (int c = 0; c < CHANNELS; c++) m_id[c] <= hit_id[c];
    end
  end

  logic [EW-1:0]       mem [CHANNELS][FIFO_DEPTH];
  logic [AW-1:0]       rd_ptr [CHANNELS];
  logic [AW-1:0]       wr_ptr [CHANNELS];
  logic [CW-1:0]       cnt [CHANNELS];
  logic [EW-1:0]       head [CHANNELS];
  logic [EW-1:0]       m_ev [CHANNELS];
  logic [CHANNELS-1:0] dflag, avail, push, pop, bypass, drop, gnt_sel;
  logic                load_en, gnt;
  logic [EW-1:0]       gnt_ev;
  logic [2:0]          gnt_idx, gnt_nptr, rr_ptr;
  logic [16:0]         ovf_sum;

  // A registered match on a channel with an empty FIFO can go straight to the output.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      m_ev[c]  = {dflag[c], m_time, m_id[c]};
      avail[c] = (cnt[c] != '0) || m_valid[c];
      head[c]  = (cnt[c] != '0) ? mem[c][rd_ptr[c]] : m_ev[c];
    end
  end

  always_comb begin : arb
    load_en  = !ev_valid || ev_ready;
    gnt      = 1'b0;
    gnt_sel  = '0;
    gnt_ev   = '0;
    gnt_idx  = '0;
    gnt_nptr = '0;
    for (int k = 0; k < CHANNELS; k++)
      for (int c = 0; c < CHANNELS; c++)
        if (load_en && !gnt && avail[c] &&
            ((int'(rr_ptr) + k == c) || (int'(rr_ptr) + k == c + CHANNELS))) begin
          gnt        = 1'b1;
          gnt_sel[c] = 1'b1;
          gnt_ev     = head[c];
          gnt_idx    = 3'(c);
          gnt_nptr   = 3'((c + 1) % CHANNELS);
        end
  end

  always_comb begin
    ovf_sum = {1'b0, overflow_count};
    for (int c = 0; c < CHANNELS; c++) begin
      bypass[c] = gnt_sel[c] && (cnt[c] == '0);
      pop[c]    = gnt_sel[c] && (cnt[c] != '0);
      drop[c]   = m_valid[c] && !bypass[c] && (cnt[c] == CW'(FIFO_DEPTH));
      push[c]   = m_valid[c] && !bypass[c] && !drop[c];
      ovf_sum   = ovf_sum + 17'(drop[c]);
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < CHANNELS; c++)
      if (push[c]) mem[c][wr_ptr[c]] <= m_ev[c];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dflag <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        rd_ptr[c] <= '0;
        wr_ptr[c] <= '0;
        cnt[c]    <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (push[c]) wr_ptr[c] <= wr_ptr[c] + AW'(1);
        if (pop[c])  rd_ptr[c] <= rd_ptr[c] + AW'(1);
        cnt[c] <= cnt[c] + CW'(push[c]) - CW'(pop[c]);
        if (drop[c])                   dflag[c] <= 1'b1;
        else if (push[c] || bypass[c]) dflag[c] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ev_valid       <= 1'b0;
      ev_id          <= '0;
      ev_time        <= '0;
      ev_channel     <= '0;
      ev_overflow    <= 1'b0;
      overflow_count <= '0;
      rr_ptr         <= '0;
    end else begin
      overflow_count <= ovf_sum[16] ? 16'hFFFF : ovf_sum[15:0];
      if (load_en) begin
        ev_valid <= gnt;
        if (gnt) begin
          {ev_overflow, ev_time, ev_id} <= gnt_ev;
          ev_channel <= gnt_idx;
          rr_ptr     <= gnt_nptr;
        end
      end
    end
  end
endmodule

// File: tb/tb_diagnosis_pc_monitor_mc.sv
// tb/tb_diagnosis_pc_monitor_mc.sv - self-checking bench for diagnosis_pc_monitor_mc
`timescale 1ns/1ps
module tb_diagnosis_pc_monitor_mc;
  localparam int CH = 2;
  localparam int NE = 4;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst, diag_sys_enabled, conf_rearm, ev_ready;
  logic [48*NE-1:0] conf_pc_flat_in;
  logic [63:0]   pc_val;
  logic [1:0]    pc_enable;
  logic [15:0]   time_global, ev_time, overflow_count;
  logic          ev_valid, ev_overflow;
  logic [4:0]    ev_id;
  logic [2:0]    ev_channel;

  always #5 clk = ~clk;

  diagnosis_pc_monitor_mc dut (
    .clk(clk), .rst(rst), .diag_sys_enabled(diag_sys_enabled),
    .conf_pc_flat_in(conf_pc_flat_in), .conf_rearm(conf_rearm),
    .pc_val(pc_val), .pc_enable(pc_enable), .time_global(time_global),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_id(ev_id), .ev_time(ev_time),
    .ev_channel(ev_channel), .ev_overflow(ev_overflow), .overflow_count(overflow_count)
  );

  int checks = 0;
  int errors = 0;

  logic        cv [NE];
  logic [1:0]  cm [NE];
  logic [4:0]  cid [NE];
  logic [31:0] cp [NE];

  typedef struct packed { logic ovf; logic [15:0] t; logic [4:0] id; } ev_t;

  typedef struct {
    logic en; logic [1:0] pe; logic [31:0] p0; logic [31:0] p1; logic [15:0] t;
    logic xv; logic [4:0] xid; logic [15:0] xt; logic [2:0] xch;
  } vec_t;
  vec_t tbl [10];

  // reference model state
  bit          mv;
  ev_t         mev;
  int          mch, mptr;
  logic [15:0] movc;
  bit          mflag [CH];
  bit          mp_v [CH];
  logic [4:0]  mp_id [CH];
  logic [15:0] mp_t;
  bit          marmed [NE];
  ev_t         mq [CH][$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic pack();
    for (int i = 0; i < NE; i++)
      conf_pc_flat_in[48*i +: 48] = {cv[i], cm[i], 8'h00, cid[i], cp[i]};
  endtask

  task automatic set_entry(input int i, input logic v, input logic [1:0] m,
                           input logic [4:0] id, input logic [31:0] pc);
    cv[i] = v; cm[i] = m; cid[i] = id; cp[i] = pc;
    pack();
  endtask

  task automatic clear_conf();
    for (int i = 0; i < NE; i++) set_entry(i, 1'b0, 2'b00, 5'd0, 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic en, input logic [1:0] pe, input logic [31:0] p0,
                       input logic [31:0] p1, input logic [15:0] t);
    diag_sys_enabled = en; pc_enable = pe; pc_val = {p1, p0}; time_global = t;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    conf_rearm = 1'b0;
    drive(1'b1, 2'b00, 32'd0, 32'd0, 16'd0);
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic model_reset();
    mv = 0; mev = '0; mch = 0; mptr = 0; movc = '0; mp_t = '0;
    for (int c = 0; c < CH; c++) begin
      mflag[c] = 0; mp_v[c] = 0; mp_id[c] = '0; mq[c].delete();
    end
    for (int i = 0; i < NE; i++) marmed[i] = 1;
  endtask

  // Index of the entry that claims pc, or -1.
  function automatic int model_match(input logic [31:0] pc);
    for (int i = 0; i < NE; i++) begin
      if (!cv[i]) continue;
      if (i > 0 && cv[i-1] && cm[i-1] == 2'b10) continue;
      if (cm[i] == 2'b00 && pc == cp[i]) return i;
      if (cm[i] == 2'b01 && marmed[i] && pc == cp[i]) return i;
      if (cm[i] == 2'b10 && i < NE - 1 && pc >= cp[i] && pc < cp[i+1]) return i;
    end
    return -1;
  endfunction

  task automatic model_step();
    int  sz [CH];
    int  r [CH];
    bit  hitv [NE];
    bit  g_any, g_q;
    int  g, c;
    g_any = 0; g_q = 0; g = 0;
    for (int k = 0; k < CH; k++) sz[k] = mq[k].size();
    if (!mv || ev_ready) begin
      for (int k = 0; k < CH; k++) begin
        c = (mptr + k) % CH;
        if (!g_any && (sz[c] > 0 || mp_v[c])) begin g_any = 1; g = c; end
      end
      if (g_any) begin
        if (sz[g] > 0) begin
          mev = mq[g].pop_front();
          g_q = 1;
        end else begin
          mev = '{ovf: mflag[g], t: mp_t, id: mp_id[g]};
          mflag[g] = 0;
        end
        mch = g;
        mptr = (g + 1) % CH;
      end
      mv = g_any;
    end
    for (int k = 0; k < CH; k++) begin
      if (mp_v[k] && !(g_any && !g_q && g == k)) begin
        if (sz[k] >= DEPTH) begin
          if (movc != 16'hFFFF) movc = movc + 16'd1;
          mflag[k] = 1;
        end else begin
          mq[k].push_back('{ovf: mflag[k], t: mp_t, id: mp_id[k]});
          mflag[k] = 0;
        end
      end
    end
    for (int i = 0; i < NE; i++) hitv[i] = 0;
    for (int k = 0; k < CH; k++) begin
      r[k] = (diag_sys_enabled && pc_enable[k]) ? model_match(pc_val[32*k +: 32]) : -1;
      mp_v[k] = (r[k] >= 0);
      mp_id[k] = '0;
      if (r[k] >= 0) begin
        mp_id[k] = cid[r[k]];
        if (cm[r[k]] == 2'b01) hitv[r[k]] = 1;
      end
    end
    mp_t = time_global;
    for (int i = 0; i < NE; i++) marmed[i] = conf_rearm ? 1'b1 : (marmed[i] && !hitv[i]);
  endtask

  initial begin
    int n, n0, n1, prev;
    rst = 1'b0;
    ev_ready = 1'b1;
    conf_rearm = 1'b0;
    drive(1'b0, 2'b00, 32'd0, 32'd0, 16'd0);
    clear_conf();
    @(negedge clk);
    do_reset();

    chk("rst_valid", ev_valid, 0);
    chk("rst_id", ev_id, 0);
    chk("rst_time", ev_time, 0);
    chk("rst_chan", ev_channel, 0);
    chk("rst_ovf", ev_overflow, 0);
    chk("rst_count", overflow_count, 0);

    // exact, range and priority vectors
    set_entry(0, 1, 2'b00, 5'd1, 32'h250);
    set_entry(1, 1, 2'b10, 5'd2, 32'h200);
    set_entry(2, 1, 2'b00, 5'd9, 32'h300);
    set_entry(3, 1, 2'b00, 5'd3, 32'h100);
    tbl[0] = '{1, 2'b01, 32'h100, 32'h0,   16'h20, 0, 5'd0, 16'h00, 3'd0};
    tbl[1] = '{1, 2'b01, 32'h250, 32'h0,   16'h21, 1, 5'd3, 16'h20, 3'd0};
    tbl[2] = '{1, 2'b01, 32'h2FF, 32'h0,   16'h22, 1, 5'd1, 16'h21, 3'd0};
    tbl[3] = '{1, 2'b01, 32'h300, 32'h0,   16'h23, 1, 5'd2, 16'h22, 3'd0};
    tbl[4] = '{1, 2'b01, 32'h200, 32'h0,   16'h24, 0, 5'd0, 16'h00, 3'd0};
    tbl[5] = '{1, 2'b01, 32'h1FF, 32'h0,   16'h25, 1, 5'd2, 16'h24, 3'd0};
    tbl[6] = '{0, 2'b01, 32'h100, 32'h0,   16'h26, 0, 5'd0, 16'h00, 3'd0};
    tbl[7] = '{1, 2'b11, 32'h100, 32'h250, 16'h27, 0, 5'd0, 16'h00, 3'd0};
    tbl[8] = '{1, 2'b00, 32'h0,   32'h0,   16'h28, 1, 5'd1, 16'h27, 3'd1};
    tbl[9] = '{1, 2'b00, 32'h0,   32'h0,   16'h29, 1, 5'd3, 16'h27, 3'd0};
    for (int r = 0; r < 10; r++) begin
      drive(tbl[r].en, tbl[r].pe, tbl[r].p0, tbl[r].p1, tbl[r].t);
      tick();
      chk("tbl_valid", ev_valid, tbl[r].xv);
      if (tbl[r].xv) begin
        chk("tbl_id", ev_id, tbl[r].xid);
        chk("tbl_time", ev_time, tbl[r].xt);
        chk("tbl_chan", ev_channel, tbl[r].xch);
        chk("tbl_ovf", ev_overflow, 0);
      end
    end

    // one-shot: single event, re-arm, dual-channel hit, re-arm coinciding with a hit
    clear_conf();
    set_entry(0, 1, 2'b01, 5'd7, 32'h40);
    drive(1, 2'b00, 32'h40, 32'h40, 16'h0);
    conf_rearm = 1; tick(); conf_rearm = 0;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      drive(1, (k < 3) ? 2'b01 : 2'b00, 32'h40, 32'h40, 16'(k));
      tick();
      if (ev_valid) begin n++; chk("os_id", ev_id, 7); end
    end
    chk("os_once", n, 1);
    conf_rearm = 1; drive(1, 2'b00, 32'h40, 32'h40, 16'h0); tick(); conf_rearm = 0;
    n = 0;
    for (int k = 0; k < 7; k++) begin
      drive(1, (k < 2) ? 2'b01 : 2'b00, 32'h40, 32'h40, 16'(k));
      tick();
      if (ev_valid) n++;
    end
    chk("os_rearm", n, 1);
    conf_rearm = 1; drive(1, 2'b00, 32'h40, 32'h40, 16'h0); tick(); conf_rearm = 0;
    n = 0;
    for (int k = 0; k < 7; k++) begin
      drive(1, (k < 2) ? 2'b11 : 2'b00, 32'h40, 32'h40, 16'(k));
      tick();
      if (ev_valid) n++;
    end
    chk("os_dual", n, 2);
    conf_rearm = 1; drive(1, 2'b00, 32'h40, 32'h40, 16'h0); tick();
    n = 0;
    for (int k = 0; k < 8; k++) begin
      conf_rearm = (k == 0);
      drive(1, (k < 3) ? 2'b01 : 2'b00, 32'h40, 32'h40, 16'(k));
      tick();
      if (ev_valid) n++;
    end
    conf_rearm = 0;
    chk("os_rearm_hit", n, 2);

    // round-robin arbitration
    clear_conf();
    set_entry(0, 1, 2'b00, 5'd5, 32'h40);
    n = 0; n0 = 0; n1 = 0; prev = -1;
    for (int k = 0; k < 12; k++) begin
      drive(1, (k < 4) ? 2'b11 : 2'b00, 32'h40, 32'h40, 16'(k));
      tick();
      if (ev_valid) begin
        n++;
        if (ev_channel == 3'd0) n0++; else n1++;
        if (prev >= 0) chk("arb_alt", (int'(ev_channel) != prev), 1);
        prev = int'(ev_channel);
      end
    end
    chk("arb_count", n, 8);
    chk("arb_ch0", n0, 4);
    chk("arb_ch1", n1, 4);

    // overflow on channel 1
    do_reset();
    ev_ready = 0;
    for (int k = 0; k < 6; k++) begin
      drive(1, 2'b10, 32'h0, 32'h40, 16'h60 + 16'(k));
      tick();
    end
    drive(1, 2'b00, 32'h0, 32'h40, 16'h0);
    tick(); tick(); tick();
    chk("ovf_count1", overflow_count, 1);
    chk("ovf_hold_valid", ev_valid, 1);
    chk("ovf_hold_chan", ev_channel, 1);
    chk("ovf_hold_time", ev_time, 16'h60);
    tick(); tick();
    chk("ovf_stable_valid", ev_valid, 1);
    chk("ovf_stable_time", ev_time, 16'h60);
    ev_ready = 1;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      if (ev_valid) begin
        chk("ovf_drain_time", ev_time, 16'h60 + 16'(n));
        chk("ovf_drain_flag", ev_overflow, 0);
        n++;
      end
      tick();
    end
    chk("ovf_drain_count", n, 5);
    drive(1, 2'b10, 32'h0, 32'h40, 16'h70); tick();
    drive(1, 2'b00, 32'h0, 32'h40, 16'h0);  tick();
    chk("ovf_flag_valid", ev_valid, 1);
    chk("ovf_flag_set", ev_overflow, 1);
    chk("ovf_flag_time", ev_time, 16'h70);
    drive(1, 2'b10, 32'h0, 32'h40, 16'h71); tick();
    drive(1, 2'b00, 32'h0, 32'h40, 16'h0);  tick();
    chk("ovf_flag_clr_valid", ev_valid, 1);
    chk("ovf_flag_clr", ev_overflow, 0);
    chk("ovf_flag_clr_time", ev_time, 16'h71);

    // saturation, then asynchronous reset mid-stream
    set_entry(1, 1, 2'b01, 5'd9, 32'h50);
    drive(1, 2'b01, 32'h50, 32'h0, 16'h0); tick();
    drive(1, 2'b00, 32'h0, 32'h0, 16'h0); tick(); tick();
    ev_ready = 0;
    drive(1, 2'b11, 32'h40, 32'h40, 16'h0);
    repeat (33000) @(posedge clk);
    @(negedge clk);
    chk("ovf_sat", overflow_count, 16'hFFFF);
    chk("mid_pre_valid", ev_valid, 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_valid", ev_valid, 0);
    chk("mid_id", ev_id, 0);
    chk("mid_time", ev_time, 0);
    chk("mid_chan", ev_channel, 0);
    chk("mid_ovf", ev_overflow, 0);
    chk("mid_count", overflow_count, 0);
    @(negedge clk);
    drive(1, 2'b00, 32'h0, 32'h0, 16'h0);
    ev_ready = 1;
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("mid_no_stale", ev_valid, 0);
    end
    drive(1, 2'b01, 32'h50, 32'h0, 16'hAB); tick();
    drive(1, 2'b00, 32'h0, 32'h0, 16'h0);   tick();
    chk("mid_rearm_valid", ev_valid, 1);
    chk("mid_rearm_id", ev_id, 9);
    chk("mid_rearm_time", ev_time, 16'hAB);
    chk("mid_rearm_ovf", ev_overflow, 0);

    // randomized run against the reference model
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      chk("rnd_valid", ev_valid, mv);
      if (mv) begin
        chk("rnd_id", ev_id, mev.id);
        chk("rnd_time", ev_time, mev.t);
        chk("rnd_chan", ev_channel, mch);
        chk("rnd_ovf", ev_overflow, mev.ovf);
      end
      chk("rnd_count", overflow_count, movc);
      if (cyc % 300 == 0) begin
        for (int i = 0; i < NE; i++)
          set_entry(i, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                    5'($urandom), 32'h10 * $urandom_range(1, 4));
      end
      begin
        logic [31:0] p [CH];
        for (int c = 0; c < CH; c++)
          p[c] = ($urandom_range(0, 1) == 1) ? cp[$urandom_range(0, NE - 1)]
                                             : 32'($urandom_range(0, 'h50));
        drive($urandom_range(0, 9) != 0, 2'($urandom), p[0], p[1], 16'($urandom));
      end
      conf_rearm = ($urandom_range(0, 31) == 0);
      if (cyc >= 1000 && cyc < 1500) ev_ready = ($urandom_range(0, 9) == 0);
      else ev_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      model_step();
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
